// File: rtl/demux8_deser_pkg.sv
// Shared definitions for the 8:1 bit-select serial link.
// Used by both the demux8_deser receiver and the matching transmitter.
package demux8_deser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BITS_PER_WORD = 8;
    localparam int IDX_W = $clog2(BITS_PER_WORD);
    localparam int CNT_W = $clog2(BITS_PER_WORD + 1);

    // First bit position of a frame, per bit order
    function automatic logic [IDX_W-1:0] idx_init(input bit lsb_first);
        return lsb_first ? '0 : IDX_W'(BITS_PER_WORD - 1);
    endfunction

endpackage

// File: rtl/demux8_deser_demux1_8.sv
// 1:8 decoder: one-hot write enable for the selected shadow bit.
// All zeros when no bit is being accepted.
module demux1_8
    import demux8_deser_pkg::*;
(
    input  logic [IDX_W-1:0]         sel_i,
    input  logic                     en_i,
    output logic [BITS_PER_WORD-1:0] we_o
);

    always_comb begin
        we_o = '0;
        if (en_i) begin
            we_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/demux8_deser.sv
// Serial-to-parallel 1:8 receiver: steers each accepted bit to
// position idx of a shadow byte and presents the byte after 8 bits.
module demux8_deser
    import demux8_deser_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     din,
    input  logic                     din_valid,
    output logic [BITS_PER_WORD-1:0] dout,
    output logic                     dout_valid,
    output logic [IDX_W-1:0]         idx,
    output logic                     busy,
    output logic                     abort
);

    localparam logic [IDX_W-1:0] IDX_INIT = idx_init(LSB_FIRST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS_PER_WORD - 1);

    state_e                   state_q;
    logic [BITS_PER_WORD-1:0] shadow_q;
    logic [BITS_PER_WORD-1:0] shadow_d;
    logic [BITS_PER_WORD-1:0] dout_q;
    logic [IDX_W-1:0]         idx_q;
    logic [IDX_W-1:0]         idx_d;
    logic [CNT_W-1:0]         cnt_q;
    logic                     dout_valid_q;
    logic                     busy_q;
    logic                     abort_q;
    logic [BITS_PER_WORD-1:0] we;
    logic                     accept;

    // start outranks a same-cycle bit
    assign accept = (state_q == RECV) && din_valid && !start;

    demux1_8 u_demux (
        .sel_i (idx_q),
        .en_i  (accept),
        .we_o  (we)
    );

    assign shadow_d = (shadow_q & ~we) | (we & {BITS_PER_WORD{din}});
    assign idx_d    = LSB_FIRST ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            dout_q       <= '0;
            idx_q        <= IDX_INIT;
            cnt_q        <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            abort_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RECV;
                        busy_q  <= 1'b1;
                    end
                end
                RECV: begin
                    if (start) begin
                        abort_q <= 1'b1;
                    end else if (accept) begin
                        shadow_q <= shadow_d;
                        idx_q    <= idx_d;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    dout_q       <= shadow_q;
                    dout_valid_q <= 1'b1;
                    state_q      <= start ? RECV : IDLE;
                    busy_q       <= start;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            // Any start opens a fresh frame; DONE above still reads the old shadow
            if (start) begin
                shadow_q <= '0;
                idx_q    <= IDX_INIT;
                cnt_q    <= '0;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign idx        = idx_q;
    assign busy       = busy_q;
    assign abort      = abort_q;

endmodule

// File: tb/tb_demux8_deser.sv
// Self-checking bench for demux8_deser, both bit orders side by side.
// A frame-level model is compared every cycle, plus literal spot checks.
module tb_demux8_deser;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       din;
    logic       din_valid;
    logic [7:0] dout0, dout1;
    logic       dv0, dv1;
    logic [2:0] idx0, idx1;
    logic       busy0, busy1;
    logic       ab0, ab1;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    int dv_cnt   = 0;
    int ab_cnt   = 0;
    int last_dv  = 0;
    int prev_dv  = 0;

    demux8_deser #(.LSB_FIRST(1'b1)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout0),
        .dout_valid (dv0),
        .idx        (idx0),
        .busy       (busy0),
        .abort      (ab0)
    );

    demux8_deser #(.LSB_FIRST(1'b0)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout1),
        .dout_valid (dv1),
        .idx        (idx1),
        .busy       (busy1),
        .abort      (ab1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level model: collected bit count plus the byte built so far
    typedef struct {
        bit         in_frame;
        bit         done_pend;
        int         nbits;
        logic [7:0] acc;
        logic [7:0] dout;
        bit         dv;
        bit         busy;
        bit         ab;
        logic [2:0] idx;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mreset(input bit lsb);
        mdl_t n;
        n.in_frame  = 0;
        n.done_pend = 0;
        n.nbits     = 0;
        n.acc       = 8'h00;
        n.dout      = 8'h00;
        n.dv        = 0;
        n.busy      = 0;
        n.ab        = 0;
        n.idx       = lsb ? 3'd0 : 3'd7;
        return n;
    endfunction

    function automatic mdl_t step(input mdl_t m, input bit lsb,
                                  input logic st, input logic v,
                                  input logic d);
        mdl_t n;
        int   pos;
        int   k;
        n    = m;
        n.dv = 0;
        n.ab = 0;
        if (m.done_pend) begin
            n.dout      = m.acc;
            n.dv        = 1;
            n.done_pend = 0;
            n.in_frame  = 0;
            n.busy      = 0;
        end
        if (st) begin
            if (m.in_frame && !m.done_pend) n.ab = 1;
            n.in_frame = 1;
            n.nbits    = 0;
            n.acc      = 8'h00;
            n.busy     = 1;
        end else if (m.in_frame && !m.done_pend && v) begin
            pos        = lsb ? m.nbits : 7 - m.nbits;
            n.acc[pos] = d;
            n.nbits    = m.nbits + 1;
            if (n.nbits == 8) n.done_pend = 1;
        end
        k     = n.nbits % 8;
        n.idx = lsb ? 3'(k) : 3'(7 - k);
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m0 = mreset(1'b1);
            m1 = mreset(1'b0);
        end else begin
            m0 = step(m0, 1'b1, start, din_valid, din);
            m1 = step(m1, 1'b0, start, din_valid, din);
        end
        cyc_n++;
        #1;
        chk("dout0",  32'(dout0), 32'(m0.dout));
        chk("dv0",    32'(dv0),   32'(m0.dv));
        chk("idx0",   32'(idx0),  32'(m0.idx));
        chk("busy0",  32'(busy0), 32'(m0.busy));
        chk("abort0", 32'(ab0),   32'(m0.ab));
        chk("dout1",  32'(dout1), 32'(m1.dout));
        chk("dv1",    32'(dv1),   32'(m1.dv));
        chk("idx1",   32'(idx1),  32'(m1.idx));
        chk("busy1",  32'(busy1), 32'(m1.busy));
        chk("abort1", 32'(ab1),   32'(m1.ab));
        if (dv0) begin
            dv_cnt++;
            prev_dv = last_dv;
            last_dv = cyc_n;
        end
        if (ab0) ab_cnt++;
    end

    task automatic cyc(input logic st, input logic v, input logic d);
        @(negedge clk);
        start     = st;
        din_valid = v;
        din       = d;
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] val, input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, val[k]);
    endtask

    int dv_base;
    int ab_base;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Plain frame; din_valid in IDLE must be ignored
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        send(8'hA5, 8);
        cyc(1'b0, 1'b0, 1'b0);
        chk("a5_dout0", 32'(dout0), 32'h A5);
        chk("a5_dout1", 32'(dout1), 32'h A5);
        chk("a5_dv",    32'(dv0),   32'd1);
        chk("a5_idx0",  32'(idx0),  32'd0);
        chk("a5_idx1",  32'(idx1),  32'd7);
        chk("a5_busy",  32'(busy0), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("a5_dv_one", 32'(dv0), 32'd0);

        // Gapped all-ones frame
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, 1'b1);
            if (k % 2 == 0) begin
                cyc(1'b0, 1'b0, 1'($urandom));
                cyc(1'b0, 1'b0, 1'($urandom));
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        chk("ff_dout0", 32'(dout0), 32'hFF);
        chk("ff_dout1", 32'(dout1), 32'hFF);

        // Restart after 3 bits; same-cycle bit with start is dropped
        dv_base = dv_cnt;
        ab_base = ab_cnt;
        cyc(1'b1, 1'b0, 1'b0);
        send(8'b0000_0011, 3);
        cyc(1'b1, 1'b1, 1'b1);
        chk("ab_pulse", 32'(ab0), 32'd1);
        send(8'h3C, 8);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("ab_count", 32'(ab_cnt - ab_base), 32'd1);
        chk("ab_dvcnt", 32'(dv_cnt - dv_base), 32'd1);
        chk("3c_dout0", 32'(dout0), 32'h3C);
        chk("3c_dout1", 32'(dout1), 32'h3C);

        // Back-to-back frames, start overlapping DONE
        cyc(1'b1, 1'b0, 1'b0);
        send(8'h12, 8);
        cyc(1'b1, 1'b0, 1'b0);
        chk("12_dout0", 32'(dout0), 32'h12);
        chk("12_dout1", 32'(dout1), 32'h48);
        chk("12_busy",  32'(busy0), 32'd1);
        send(8'h34, 8);
        cyc(1'b0, 1'b0, 1'b0);
        chk("34_dout0", 32'(dout0), 32'h34);
        chk("34_dout1", 32'(dout1), 32'h2C);
        chk("b2b_gap",  32'(last_dv - prev_dv), 32'd9);

        // Async reset after 5 bits
        cyc(1'b1, 1'b0, 1'b0);
        send(8'hFF, 5);
        #3;
        dv_base = dv_cnt;
        rst_n   = 1'b0;
        #1;
        chk("rst_dout0", 32'(dout0), 32'h00);
        chk("rst_dout1", 32'(dout1), 32'h00);
        chk("rst_busy",  32'(busy0), 32'd0);
        chk("rst_dv",    32'(dv0),   32'd0);
        chk("rst_ab",    32'(ab0),   32'd0);
        chk("rst_idx0",  32'(idx0),  32'd0);
        chk("rst_idx1",  32'(idx1),  32'd7);
        start     = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        send(8'h81, 8);
        cyc(1'b0, 1'b0, 1'b0);
        chk("81_dout0", 32'(dout0), 32'h81);
        chk("81_dout1", 32'(dout1), 32'h81);
        chk("81_dvcnt", 32'(dv_cnt - dv_base), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
